decode: RTL and testbench
=========================

# decode

Instruction decode stage of the in-order RV32I pipeline, directly downstream of instruction fetch. Consumes the fetch stage's `if_id__*` bundle and `pipe_flush`, reads the 32×32 register file, generates immediates and control, and registers everything into the `id_ex__*` bundle for execute. Owns load-use hazard detection: it drives `data_hazard` back to fetch and inserts a bubble.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `if_id__pc`  in  32  PC of the instruction in `if_id__ins`.
- `if_id__ins`  in  32  instruction word from synchronous imem.
- `if_id__ins_misalign`  in  1  fetch PC misaligned.
- `pipe_flush`  in  1  `if_id__ins` is wrong-path; treat as bubble.
- `mb_id__jump_taken`  in  1  branch/jump resolved taken this cycle; kill the instruction now in decode.
- `wb_id__we`  in  1  register write enable.
- `wb_id__rd`  in  5  write register index.
- `wb_id__data`  in  32  write data.
- `data_hazard`  out  1  combinational load-use stall request to fetch.
- `id_ex__valid`  out  1  slot holds a real instruction.
- `id_ex__pc`  out  32
- `id_ex__rs1`, `id_ex__rs2`, `id_ex__rd`  out  5 each
- `id_ex__rs1_data`, `id_ex__rs2_data`  out  32 each
- `id_ex__imm`  out  32  sign-extended immediate.
- `id_ex__opcode`  out  7  `ins[6:0]`.
- `id_ex__funct3`  out  3  `ins[14:12]`.
- `id_ex__funct7b5`  out  1  `ins[30]`.
- `id_ex__reg_write`, `id_ex__mem_read`, `id_ex__mem_write`  out  1 each
- `id_ex__ins_misalign`  out  1
- `id_ex__illegal`  out  1  see Configuration.

## Operation
- Register file: 32 entries; x0 reads 0, writes to x0 are ignored. Reads are combinational, with a write-through bypass: if `wb_id__we`, `wb_id__rd`≠0 and `wb_id__rd` matches rs, the read returns `wb_id__data`.
- Immediate by opcode: I (`0010011`, `0000011`, `1100111`), S (`0100011`), B (`1100011`), U (`0110111`, `0010111`), J (`1101111`). All other opcodes give imm = 0. Immediates are sign-extended from `ins[31]`.
- Control: reg_write for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd≠0. mem_read for LOAD. mem_write for STORE.
- rs usage: rs1 is used by all except LUI, AUIPC and JAL. rs2 is used by OP, STORE and BRANCH. An unused rs field is output as 0.
- `in_valid` = !`pipe_flush` & !`mb_id__jump_taken`.
- `data_hazard` = `in_valid` & `id_ex__valid` & `id_ex__mem_read` & `id_ex__rd`≠0 & (rs1 used and equal to `id_ex__rd`, or rs2 used and equal to `id_ex__rd`).
- Next `id_ex` value, in priority order:
  1. `rst` → bubble.
  2. !`in_valid` → bubble.
  3. `data_hazard` → bubble. Fetch holds the PC and the instruction, so the same instruction is re-decoded next cycle.
  4. Otherwise → decoded instruction, valid = 1.
- Bubble = valid, reg_write, mem_read, mem_write, illegal, ins_misalign all 0; every other field 0.
- The register file is not cleared by reset; its contents are undefined except x0.

## Timing
- Reset value of every `id_ex__*` output is 0. `data_hazard` is 0 during reset and in the cycle after it.
- Latency: 1 cycle from `if_id__*` to `id_ex__*`.
- A load-use hazard costs exactly 1 bubble. The stall deasserts on the following cycle because `id_ex` then holds the bubble.
- `mb_id__jump_taken` and `pipe_flush` together kill 2 consecutive decode slots after a taken jump: the in-flight slot, then the wrong-path fetch.
- A regfile write at edge N is visible to a decode read in cycle N through the bypass.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - An opcode outside the RV32I set above, or `ins[1:0]`≠`11`, yields valid = 1, illegal = 1, and reg_write, mem_read, mem_write = 0.
  - `id_ex__ins_misalign` also forces those three controls to 0.
- Undefined:
  - `id_ex__illegal` is tied to 0.
  - Unknown opcodes pass through with all controls 0.
  - ins_misalign is passed through only; it does not gate controls.

## Test plan
- Reset: hold `rst` 2 cycles → every `id_ex__*` = 0 and `data_hazard` = 0.
- `addi x1,x0,-5` (0xFFB00093) at pc 0x10 → `id_ex__imm` = 0xFFFFFFFB, rd = 1, reg_write = 1, pc = 0x10, valid = 1.
- Load-use: `lw x5,0(x2)` then `add x6,x5,x7`:
  - `data_hazard` = 1 for exactly 1 cycle.
  - One bubble, then the add issues with rs1 = 5.
  - `add x6,x0,x7` after the same load → no hazard.
- Bypass: `wb_id__we`=1, rd = 3, data = 0xDEADBEEF in the same cycle as `add x4,x3,x3` → rs1_data = rs2_data = 0xDEADBEEF. A write to x0 → reads stay 0.
- Flush:
  - `mb_id__jump_taken` pulse → bubble next cycle.
  - Then `pipe_flush` = 1 → a second bubble.
  - A load-use pattern present at the same time → `data_hazard` = 0.
- Macro on: ins 0x0000007F → valid = 1, illegal = 1, reg_write = 0. Macro off: same input → illegal = 0.

Source files
------------

// File: rtl/decode.sv
// decode: RV32I instruction decode stage.
// Reads the register file (with write-through bypass), builds the sign-extended
// immediate and control bits, detects load-use hazards and registers the
// result into the id_ex bundle.
// Optional feature macro: DECODE_ILLEGAL_EN flags unknown opcodes as illegal
// and suppresses side-effecting controls for illegal or misaligned slots.
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id__pc,
    input  logic [31:0] if_id__ins,
    input  logic        if_id__ins_misalign,
    input  logic        pipe_flush,
    input  logic        mb_id__jump_taken,
    input  logic        wb_id__we,
    input  logic [4:0]  wb_id__rd,
    input  logic [31:0] wb_id__data,
    output logic        data_hazard,
    output logic        id_ex__valid,
    output logic [31:0] id_ex__pc,
    output logic [4:0]  id_ex__rs1,
    output logic [4:0]  id_ex__rs2,
    output logic [4:0]  id_ex__rd,
    output logic [31:0] id_ex__rs1_data,
    output logic [31:0] id_ex__rs2_data,
    output logic [31:0] id_ex__imm,
    output logic [6:0]  id_ex__opcode,
    output logic [2:0]  id_ex__funct3,
    output logic        id_ex__funct7b5,
    output logic        id_ex__reg_write,
    output logic        id_ex__mem_read,
    output logic        id_ex__mem_write,
    output logic        id_ex__ins_misalign,
    output logic        id_ex__illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0] regs [31:0];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic        in_valid;

    assign opcode   = if_id__ins[6:0];
    assign rd       = if_id__ins[11:7];
    assign in_valid = !pipe_flush && !mb_id__jump_taken;

    // Register file write port; x0 is never written.
    always_ff @(posedge clk) begin
        if (wb_id__we && wb_id__rd != 5'd0) begin
            regs[wb_id__rd] <= wb_id__data;
        end
    end

    // Field decode, immediate generation, control and bypassed register reads.
    always_comb begin
        imm = '0;
        unique case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{if_id__ins[31]}}, if_id__ins[31:20]};
            OPC_STORE:
                imm = {{20{if_id__ins[31]}}, if_id__ins[31:25], if_id__ins[11:7]};
            OPC_BRANCH:
                imm = {{19{if_id__ins[31]}}, if_id__ins[31], if_id__ins[7],
                       if_id__ins[30:25], if_id__ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {if_id__ins[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{if_id__ins[31]}}, if_id__ins[31], if_id__ins[19:12],
                       if_id__ins[20], if_id__ins[30:21], 1'b0};
            default:
                imm = '0;
        endcase

        rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        rs2_used = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        rs1      = rs1_used ? if_id__ins[19:15] : '0;
        rs2      = rs2_used ? if_id__ins[24:20] : '0;

        reg_write = (opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
                                    OPC_AUIPC, OPC_JAL, OPC_JALR}) && (rd != 5'd0);
        mem_read  = (opcode == OPC_LOAD);
        mem_write = (opcode == OPC_STORE);

`ifdef DECODE_ILLEGAL_EN
        illegal = !(opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                   OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC})
                  || (if_id__ins[1:0] != 2'b11);
        if (illegal || if_id__ins_misalign) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
`else
        illegal = 1'b0;
`endif

        // Write-through bypass: a write landing this edge is seen by this read.
        rs1_data = '0;
        if (rs1 != 5'd0) begin
            rs1_data = (wb_id__we && wb_id__rd == rs1) ? wb_id__data : regs[rs1];
        end
        rs2_data = '0;
        if (rs2 != 5'd0) begin
            rs2_data = (wb_id__we && wb_id__rd == rs2) ? wb_id__data : regs[rs2];
        end
    end

    // Load-use stall request; held low through reset so uninitialised id_ex cannot leak.
    assign data_hazard = !rst && in_valid && id_ex__valid && id_ex__mem_read
                         && (id_ex__rd != 5'd0)
                         && ((rs1_used && rs1 == id_ex__rd) || (rs2_used && rs2 == id_ex__rd));

    // id_ex pipeline register: bubble on reset, kill or stall, else the decoded slot.
    always_ff @(posedge clk) begin
        if (rst || !in_valid || data_hazard) begin
            id_ex__valid        <= 1'b0;
            id_ex__pc           <= '0;
            id_ex__rs1          <= '0;
            id_ex__rs2          <= '0;
            id_ex__rd           <= '0;
            id_ex__rs1_data     <= '0;
            id_ex__rs2_data     <= '0;
            id_ex__imm          <= '0;
            id_ex__opcode       <= '0;
            id_ex__funct3       <= '0;
            id_ex__funct7b5     <= 1'b0;
            id_ex__reg_write    <= 1'b0;
            id_ex__mem_read     <= 1'b0;
            id_ex__mem_write    <= 1'b0;
            id_ex__ins_misalign <= 1'b0;
            id_ex__illegal      <= 1'b0;
        end else begin
            id_ex__valid        <= 1'b1;
            id_ex__pc           <= if_id__pc;
            id_ex__rs1          <= rs1;
            id_ex__rs2          <= rs2;
            id_ex__rd           <= rd;
            id_ex__rs1_data     <= rs1_data;
            id_ex__rs2_data     <= rs2_data;
            id_ex__imm          <= imm;
            id_ex__opcode       <= opcode;
            id_ex__funct3       <= if_id__ins[14:12];
            id_ex__funct7b5     <= if_id__ins[30];
            id_ex__reg_write    <= reg_write;
            id_ex__mem_read     <= mem_read;
            id_ex__mem_write    <= mem_write;
            id_ex__ins_misalign <= if_id__ins_misalign;
            id_ex__illegal      <= illegal;
        end
    end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed-vector bench for the decode stage with an
// instruction-level reference model and per-cycle comparison.
`timescale 1ns/1ps
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id__pc;
    logic [31:0] if_id__ins;
    logic        if_id__ins_misalign;
    logic        pipe_flush;
    logic        mb_id__jump_taken;
    logic        wb_id__we;
    logic [4:0]  wb_id__rd;
    logic [31:0] wb_id__data;
    logic        data_hazard;
    logic        id_ex__valid;
    logic [31:0] id_ex__pc;
    logic [4:0]  id_ex__rs1, id_ex__rs2, id_ex__rd;
    logic [31:0] id_ex__rs1_data, id_ex__rs2_data, id_ex__imm;
    logic [6:0]  id_ex__opcode;
    logic [2:0]  id_ex__funct3;
    logic        id_ex__funct7b5, id_ex__reg_write, id_ex__mem_read, id_ex__mem_write;
    logic        id_ex__ins_misalign, id_ex__illegal;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rst(rst),
        .if_id__pc(if_id__pc), .if_id__ins(if_id__ins),
        .if_id__ins_misalign(if_id__ins_misalign),
        .pipe_flush(pipe_flush), .mb_id__jump_taken(mb_id__jump_taken),
        .wb_id__we(wb_id__we), .wb_id__rd(wb_id__rd), .wb_id__data(wb_id__data),
        .data_hazard(data_hazard),
        .id_ex__valid(id_ex__valid), .id_ex__pc(id_ex__pc),
        .id_ex__rs1(id_ex__rs1), .id_ex__rs2(id_ex__rs2), .id_ex__rd(id_ex__rd),
        .id_ex__rs1_data(id_ex__rs1_data), .id_ex__rs2_data(id_ex__rs2_data),
        .id_ex__imm(id_ex__imm), .id_ex__opcode(id_ex__opcode),
        .id_ex__funct3(id_ex__funct3), .id_ex__funct7b5(id_ex__funct7b5),
        .id_ex__reg_write(id_ex__reg_write), .id_ex__mem_read(id_ex__mem_read),
        .id_ex__mem_write(id_ex__mem_write),
        .id_ex__ins_misalign(id_ex__ins_misalign), .id_ex__illegal(id_ex__illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data, imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5, reg_write, mem_read, mem_write, ins_misalign, illegal;
    } slot_t;

    int    checks = 0;
    int    errors = 0;
    bit    started = 1'b0;
    slot_t exp_s = '0;
    logic [31:0] shadow [32];

    // Architectural read as decode sees it in the current cycle.
    function automatic logic [31:0] arch_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_id__we && wb_id__rd == r) return wb_id__data;
        return shadow[r];
    endfunction

    // Instruction-level model: format class drives everything else.
    function automatic slot_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic mis);
        slot_t s;
        byte   fmt;
        int    v;
        logic  legal;
        s = '0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: fmt = "I";
            7'h23:               fmt = "S";
            7'h63:               fmt = "B";
            7'h37, 7'h17:        fmt = "U";
            7'h6F:               fmt = "J";
            7'h33:               fmt = "R";
            default:             fmt = "?";
        endcase
        v = 0;
        if (fmt == "I") begin
            v = ins[31:20];
            if (ins[31]) v = v - 4096;
        end else if (fmt == "S") begin
            v = {ins[31:25], ins[11:7]};
            if (ins[31]) v = v - 4096;
        end else if (fmt == "B") begin
            v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            if (ins[31]) v = v - 8192;
        end else if (fmt == "J") begin
            v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            if (ins[31]) v = v - (1 << 21);
        end
        s.imm = (fmt == "U") ? (ins & 32'hFFFF_F000) : 32'(v);
        s.valid    = 1'b1;
        s.pc       = pc;
        s.rd       = ins[11:7];
        s.rs1      = (fmt == "U" || fmt == "J") ? 5'd0 : ins[19:15];
        s.rs2      = (fmt == "R" || fmt == "S" || fmt == "B") ? ins[24:20] : 5'd0;
        s.rs1_data = arch_read(s.rs1);
        s.rs2_data = arch_read(s.rs2);
        s.opcode   = ins[6:0];
        s.funct3   = ins[14:12];
        s.funct7b5 = ins[30];
        s.reg_write = (fmt == "I" || fmt == "U" || fmt == "J" || fmt == "R") && s.rd != 0;
        s.mem_read  = (ins[6:0] == 7'h03);
        s.mem_write = (fmt == "S");
        s.ins_misalign = mis;
        legal = (fmt != "?") && (ins[1:0] == 2'b11);
        if (ILL_EN) begin
            s.illegal = !legal;
            if (!legal || mis) begin
                s.reg_write = 1'b0;
                s.mem_read  = 1'b0;
                s.mem_write = 1'b0;
            end
        end
        return s;
    endfunction

    function automatic logic model_hz();
        slot_t d;
        if (rst || pipe_flush || mb_id__jump_taken) return 1'b0;
        if (!(exp_s.valid && exp_s.mem_read && exp_s.rd != 5'd0)) return 1'b0;
        d = model_decode(if_id__ins, if_id__pc, if_id__ins_misalign);
        return (d.rs1 == exp_s.rd) || (d.rs2 == exp_s.rd);
    endfunction

    // Reference model advances on each rising edge.
    always @(posedge clk) begin
        slot_t nxt;
        if (rst || pipe_flush || mb_id__jump_taken || model_hz()) nxt = '0;
        else nxt = model_decode(if_id__ins, if_id__pc, if_id__ins_misalign);
        if (wb_id__we && wb_id__rd != 5'd0) shadow[wb_id__rd] = wb_id__data;
        exp_s   = nxt;
        started = 1'b1;
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        slot_t act;
        logic  hz;
        if (started) begin
            act = {id_ex__valid, id_ex__pc, id_ex__rs1, id_ex__rs2, id_ex__rd,
                   id_ex__rs1_data, id_ex__rs2_data, id_ex__imm, id_ex__opcode,
                   id_ex__funct3, id_ex__funct7b5, id_ex__reg_write, id_ex__mem_read,
                   id_ex__mem_write, id_ex__ins_misalign, id_ex__illegal};
            hz = model_hz();
            checks++;
            if (act !== exp_s) begin
                errors++;
                $display("FAIL id_ex_slot @%0t: got %h expected %h", $time, act, exp_s);
            end
            checks++;
            if (data_hazard !== hz) begin
                errors++;
                $display("FAIL data_hazard_model @%0t: got %b expected %b", $time, data_hazard, hz);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        if_id__ins = ins;
        if_id__pc  = pc;
    endtask

    logic [31:0] table_ins [8] = '{32'h402081B3, 32'h12345517, 32'hFFFFF517, 32'h8000006F,
                                   32'h004280E7, 32'h00000013, 32'h0000000F, 32'h00712423};

    initial begin
        rst = 1'b1; if_id__pc = '0; if_id__ins = '0; if_id__ins_misalign = 1'b0;
        pipe_flush = 1'b0; mb_id__jump_taken = 1'b0;
        wb_id__we = 1'b0; wb_id__rd = '0; wb_id__data = '0;

        cyc(); cyc();
        chk("rst_valid", {31'd0, id_ex__valid}, 32'd0);
        chk("rst_pc", id_ex__pc, 32'd0);
        chk("rst_imm", id_ex__imm, 32'd0);
        chk("rst_reg_write", {31'd0, id_ex__reg_write}, 32'd0);
        chk("rst_hazard", {31'd0, data_hazard}, 32'd0);

        rst = 1'b0; pipe_flush = 1'b1;
        #1 chk("post_rst_hazard", {31'd0, data_hazard}, 32'd0);
        for (int r = 1; r < 32; r++) begin
            wb_id__we = 1'b1; wb_id__rd = 5'(r); wb_id__data = 32'h1000_0000 + r * 32'h0101;
            cyc();
        end
        wb_id__we = 1'b0; pipe_flush = 1'b0;

        present(32'hFFB00093, 32'h10); cyc();
        chk("addi_imm", id_ex__imm, 32'hFFFF_FFFB);
        chk("addi_rd", {27'd0, id_ex__rd}, 32'd1);
        chk("addi_reg_write", {31'd0, id_ex__reg_write}, 32'd1);
        chk("addi_pc", id_ex__pc, 32'h10);
        chk("addi_valid", {31'd0, id_ex__valid}, 32'd1);

        present(32'h00012283, 32'h14); cyc();
        present(32'h00728333, 32'h18);
        #1 chk("lu_hazard_on", {31'd0, data_hazard}, 32'd1);
        cyc();
        chk("lu_bubble", {31'd0, id_ex__valid}, 32'd0);
        chk("lu_hazard_off", {31'd0, data_hazard}, 32'd0);
        cyc();
        chk("lu_add_valid", {31'd0, id_ex__valid}, 32'd1);
        chk("lu_add_rs1", {27'd0, id_ex__rs1}, 32'd5);

        present(32'h00012283, 32'h1C); cyc();
        present(32'h00700333, 32'h20);
        #1 chk("lu_x0_no_hazard", {31'd0, data_hazard}, 32'd0);
        cyc();
        chk("lu_x0_valid", {31'd0, id_ex__valid}, 32'd1);

        present(32'h00012283, 32'h24); cyc();
        present(32'h00512023, 32'h28);
        #1 chk("lu_store_rs2_hazard", {31'd0, data_hazard}, 32'd1);
        cyc(); cyc();
        chk("lu_store_mem_write", {31'd0, id_ex__mem_write}, 32'd1);

        present(32'h00318233, 32'h30);
        wb_id__we = 1'b1; wb_id__rd = 5'd3; wb_id__data = 32'hDEAD_BEEF;
        cyc(); wb_id__we = 1'b0;
        chk("bypass_rs1", id_ex__rs1_data, 32'hDEAD_BEEF);
        chk("bypass_rs2", id_ex__rs2_data, 32'hDEAD_BEEF);

        present(32'h00000233, 32'h34);
        wb_id__we = 1'b1; wb_id__rd = 5'd0; wb_id__data = 32'h1234_5678;
        cyc(); wb_id__we = 1'b0;
        chk("x0_rs1", id_ex__rs1_data, 32'd0);
        chk("x0_rs2", id_ex__rs2_data, 32'd0);

        present(32'h00012283, 32'h40); cyc();
        present(32'h00728333, 32'h44); mb_id__jump_taken = 1'b1;
        #1 chk("jump_masks_hazard", {31'd0, data_hazard}, 32'd0);
        cyc();
        mb_id__jump_taken = 1'b0; pipe_flush = 1'b1;
        chk("jump_bubble", {31'd0, id_ex__valid}, 32'd0);
        present(32'hFFB00093, 32'h48); cyc();
        pipe_flush = 1'b0;
        chk("flush_bubble", {31'd0, id_ex__valid}, 32'd0);

        present(32'h0000007F, 32'h50); cyc();
        chk("ill_valid", {31'd0, id_ex__valid}, 32'd1);
        chk("ill_flag", {31'd0, id_ex__illegal}, {31'd0, ILL_EN});
        chk("ill_reg_write", {31'd0, id_ex__reg_write}, 32'd0);

        present(32'h123454B7, 32'h54); cyc();
        chk("lui_imm", id_ex__imm, 32'h1234_5000);
        present(32'hFE208EE3, 32'h58); cyc();
        chk("beq_imm", id_ex__imm, 32'hFFFF_FFFC);
        chk("beq_rs2", {27'd0, id_ex__rs2}, 32'd2);

        for (int i = 0; i < 8; i++) begin
            present(table_ins[i], 32'h100 + 32'(i) * 4);
            cyc();
        end
        present(32'h00000010, 32'h120); cyc();

        present(32'h0041A403, 32'h124); if_id__ins_misalign = 1'b1; cyc();
        if_id__ins_misalign = 1'b0;
        chk("mis_flag", {31'd0, id_ex__ins_misalign}, 32'd1);
        chk("mis_mem_read", {31'd0, id_ex__mem_read}, {31'd0, !ILL_EN});
        present(32'h00000013, 32'h128); cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
